// File: rtl/sd_avg_sched.sv
// sd_avg_sched: round-robin scheduler sharing one two-input sigma-delta
// averager among NUM_REQ sigma-delta sources.
//
// Each slot grants up to two requesting sources. The averager is flushed
// for one cycle. The two granted bitstreams are then routed to the
// averager inputs while a programmable divider produces the enable strobe.
// After SLOT_LEN strobes the pointer rotates past the last served source.
// A slot also ends when any granted request drops.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   div      enable period minus one (0 = strobe every cycle)
//   req      per-source request level
//   sd_in    per-source sigma-delta bit
//   grant    registered one-hot / two-hot grant
//   busy     high in FLUSH and RUN
//   avg_rst  registered synchronous reset for the averager
//   avg_en   registered enable strobe for the averager
//   avg_in0  bitstream of the first granted source
//   avg_in1  bitstream of the second granted source, or the midscale pad bit
module sd_avg_sched #(
  parameter int NUM_REQ  = 4,
  parameter int DIV_W    = 8,
  parameter int SLOT_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   div,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] sd_in,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               avg_rst,
  output logic               avg_en,
  output logic               avg_in0,
  output logic               avg_in1
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(SLOT_LEN + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [PW-1:0]      g0, g0_nxt, g1, g1_nxt;
  logic [PW-1:0]      pick0, pick1;
  logic               found0, found1;
  logic               dual, dual_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               avg_rst_nxt, avg_en_nxt;
  logic               pad, pad_nxt;
  logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
  logic [SW-1:0]      slot_cnt, slot_cnt_nxt;
  logic               released, last_strobe;

  // Cyclic index addition; off never exceeds NUM_REQ so one wrap suffices.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NUM_REQ) t = t - NUM_REQ;
    return PW'(t);
  endfunction

  // Round-robin search: g0 is the first request at/after ptr, g1 the next
  // one after g0 in cyclic order.
  always_comb begin
    found0 = 1'b0;
    pick0  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found0 && req[wrap_idx(ptr, i)]) begin
        found0 = 1'b1;
        pick0  = wrap_idx(ptr, i);
      end
    end
    found1 = 1'b0;
    pick1  = pick0;
    for (int i = 1; i < NUM_REQ; i++) begin
      if (!found1 && req[wrap_idx(pick0, i)]) begin
        found1 = 1'b1;
        pick1  = wrap_idx(pick0, i);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    g0_nxt       = g0;
    g1_nxt       = g1;
    dual_nxt     = dual;
    grant_nxt    = grant;
    avg_rst_nxt  = 1'b1;
    avg_en_nxt   = 1'b0;
    pad_nxt      = pad;
    div_cnt_nxt  = div_cnt;
    slot_cnt_nxt = slot_cnt;
    released     = (req & grant) != grant;
    last_strobe  = avg_en && (slot_cnt == SW'(SLOT_LEN - 1));

    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (req != '0) begin
          state_nxt    = FLUSH;
          g0_nxt       = pick0;
          g1_nxt       = pick1;
          dual_nxt     = found1;
          grant_nxt    = (NUM_REQ'(1) << pick0) | (found1 ? (NUM_REQ'(1) << pick1) : '0);
          div_cnt_nxt  = '0;
          slot_cnt_nxt = '0;
          pad_nxt      = 1'b0;
        end
      end

      FLUSH: begin
        // Counter is zero here, so the first RUN cycle always strobes.
        state_nxt   = RUN;
        avg_rst_nxt = 1'b0;
        avg_en_nxt  = 1'b1;
        div_cnt_nxt = div;
      end

      RUN: begin
        if (avg_en) begin
          slot_cnt_nxt = slot_cnt + 1'b1;
          pad_nxt      = ~pad;
        end
        // A dropped request wins over the final strobe; both end the slot.
        if (released || last_strobe) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = wrap_idx(dual ? g1 : g0, 1);
        end else begin
          avg_rst_nxt = 1'b0;
          if (div_cnt == '0) begin
            avg_en_nxt  = 1'b1;
            div_cnt_nxt = div;
          end else begin
            div_cnt_nxt = div_cnt - 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      g0       <= '0;
      g1       <= '0;
      dual     <= 1'b0;
      grant    <= '0;
      avg_rst  <= 1'b1;
      avg_en   <= 1'b0;
      pad      <= 1'b0;
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      g0       <= g0_nxt;
      g1       <= g1_nxt;
      dual     <= dual_nxt;
      grant    <= grant_nxt;
      avg_rst  <= avg_rst_nxt;
      avg_en   <= avg_en_nxt;
      pad      <= pad_nxt;
      div_cnt  <= div_cnt_nxt;
      slot_cnt <= slot_cnt_nxt;
    end
  end

  assign busy = (state != IDLE);

  // With a single grant the pad bit alternates 0,1 per strobe, which
  // contributes a midscale value to the averager.
  always_comb begin
    avg_in0 = 1'b0;
    avg_in1 = 1'b0;
    if (grant != '0) begin
      avg_in0 = sd_in[g0];
      avg_in1 = dual ? sd_in[g1] : pad;
    end
  end
endmodule

// File: tb/tb_sd_avg_sched.sv
// Testbench for sd_avg_sched with NUM_REQ=4, DIV_W=8, SLOT_LEN=4.
module tb_sd_avg_sched;
  localparam int NUM_REQ  = 4;
  localparam int DIV_W    = 8;
  localparam int SLOT_LEN = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [DIV_W-1:0]   div;
  logic [NUM_REQ-1:0] req, sd_in, grant;
  logic               busy, avg_rst, avg_en, avg_in0, avg_in1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] sd;
    logic [7:0] div;
    logic [3:0] grant;
    logic       busy;
    logic       arst;
    logic       en;
    logic       in0;
    logic       in1;
  } vec_t;

  vec_t tbl[$];
  int   exp_en[8];
  int   exp_bz[8];

  always #5 clk = ~clk;

  sd_avg_sched #(.NUM_REQ(NUM_REQ), .DIV_W(DIV_W), .SLOT_LEN(SLOT_LEN)) dut (
    .clk(clk), .rst(rst), .div(div), .req(req), .sd_in(sd_in),
    .grant(grant), .busy(busy), .avg_rst(avg_rst), .avg_en(avg_en),
    .avg_in0(avg_in0), .avg_in1(avg_in1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] r, input logic [3:0] s, input logic [7:0] d,
                              input logic [3:0] g, input logic b, input logic ar,
                              input logic e, input logic i0, input logic i1);
    vec_t v;
    v.req = r; v.sd = s; v.div = d; v.grant = g;
    v.busy = b; v.arst = ar; v.en = e; v.in0 = i0; v.in1 = i1;
    tbl.push_back(v);
  endfunction

  initial begin
    int strobes, ones;
    logic [8:0] act_o, exp_o;

    // Dual grant, div=0, req=1111: 0011 -> 1100 -> 0011
    add(4'b1111, 4'b0001, 8'd0, 4'b0011, 1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(4'b1111, 4'b0001, 8'd0, 4'b0011, 1, 0, 1, 1, 0);
    add(4'b1111, 4'b0001, 8'd0, 4'b0000, 0, 1, 0, 0, 0);
    add(4'b1111, 4'b0100, 8'd0, 4'b1100, 1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(4'b1111, 4'b0100, 8'd0, 4'b1100, 1, 0, 1, 1, 0);
    add(4'b1111, 4'b0100, 8'd0, 4'b0000, 0, 1, 0, 0, 0);
    add(4'b1111, 4'b0010, 8'd0, 4'b0011, 1, 1, 0, 0, 1);
    add(4'b1111, 4'b0010, 8'd0, 4'b0011, 1, 0, 1, 0, 1);
    add(4'b0000, 4'b0010, 8'd0, 4'b0000, 0, 1, 0, 0, 0);
    add(4'b0000, 4'b0100, 8'd2, 4'b0000, 0, 1, 0, 0, 0);
    // Single requester, div=2: strobe every 3rd cycle, pad 0,1,0,1
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 1, 0, 1, 0);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 1, 1, 0);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 0, 1, 1);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 0, 1, 1);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 1, 1, 1);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 0, 1, 0);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 0, 1, 0);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 1, 1, 0);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 0, 1, 1);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 0, 1, 1);
    add(4'b0100, 4'b0100, 8'd2, 4'b0100, 1, 0, 1, 1, 1);
    add(4'b0100, 4'b0100, 8'd2, 4'b0000, 0, 1, 0, 0, 0);
    // Wrap: ptr=3, req=1001 -> grant 1001 with g0=3, g1=0, then again from ptr=1
    add(4'b0000, 4'b1000, 8'd0, 4'b0000, 0, 1, 0, 0, 0);
    add(4'b1001, 4'b1000, 8'd0, 4'b1001, 1, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(4'b1001, 4'b1000, 8'd0, 4'b1001, 1, 0, 1, 1, 0);
    add(4'b1001, 4'b1000, 8'd0, 4'b0000, 0, 1, 0, 0, 0);
    add(4'b1001, 4'b0001, 8'd0, 4'b1001, 1, 1, 0, 0, 1);
    add(4'b0000, 4'b0001, 8'd0, 4'b1001, 1, 0, 1, 0, 1);
    add(4'b0000, 4'b0001, 8'd0, 4'b0000, 0, 1, 0, 0, 0);
    add(4'b0000, 4'b0001, 8'd0, 4'b0000, 0, 1, 0, 0, 0);

    // Reset state
    rst = 1'b1; req = '0; sd_in = '0; div = '0;
    tick(); tick();
    check("reset_grant", grant, 4'b0000);
    check("reset_ctrl", {busy, avg_rst, avg_en, avg_in0, avg_in1}, 5'b01000);
    @(negedge clk);
    rst = 1'b0;

    strobes = 0;
    ones    = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      req   = tbl[i].req;
      sd_in = tbl[i].sd;
      div   = tbl[i].div;
      tick();
      act_o = {grant, busy, avg_rst, avg_en, avg_in0, avg_in1};
      exp_o = {tbl[i].grant, tbl[i].busy, tbl[i].arst, tbl[i].en, tbl[i].in0, tbl[i].in1};
      n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL vec%0d: got grant=%b busy=%b rst=%b en=%b in0=%b in1=%b expected grant=%b busy=%b rst=%b en=%b in0=%b in1=%b",
                 i, grant, busy, avg_rst, avg_en, avg_in0, avg_in1,
                 tbl[i].grant, tbl[i].busy, tbl[i].arst, tbl[i].en, tbl[i].in0, tbl[i].in1);
      end
      if (grant == 4'b0100 && avg_en) begin
        strobes++;
        ones += int'(avg_in0) + int'(avg_in1);
      end
    end
    // Density 3/4: 6 ones out of 2 inputs x 4 strobes
    check("single_strobes", strobes, 4);
    check("single_density_ones", ones, 6);

    // Asynchronous reset mid-RUN, then restart with req held
    req = 4'b0011; sd_in = 4'b0001; div = '0;
    tick();
    check("pre_rst_flush_grant", grant, 4'b0011);
    tick();
    check("pre_rst_run_en", avg_en, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_grant", grant, 4'b0000);
    check("midrst_ctrl", {busy, avg_rst, avg_en}, 3'b010);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_grant", grant, 4'b0011);
    check("post_rst_flush", {busy, avg_rst, avg_en}, 3'b110);
    tick();
    check("post_rst_strobe1", {avg_rst, avg_en}, 2'b01);
    tick();
    check("post_rst_strobe2", avg_en, 1);

    // Early release: req[1] drops at the 2nd strobe
    req = 4'b0001;
    tick();
    check("early_grant", grant, 4'b0000);
    check("early_ctrl", {busy, avg_rst, avg_en}, 3'b010);
    req = 4'b0000;
    tick();
    check("early_no_en", {busy, avg_en}, 2'b00);
    req = 4'b1111;
    tick();
    check("early_next_ptr2", grant, 4'b1100);
    req = 4'b0000;
    tick();
    tick();
    check("early_second_release", busy, 0);

    // Divider change 0 -> 3 mid-RUN
    exp_en = '{1, 1, 1, 0, 0, 0, 1, 0};
    exp_bz = '{1, 1, 1, 1, 1, 1, 1, 0};
    req = 4'b0001; sd_in = 4'b0001; div = 8'd0;
    tick();
    check("divchg_flush", {grant, avg_rst}, 5'b00011);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) div = 8'd3;
      tick();
      check($sformatf("divchg_en%0d", i), avg_en, exp_en[i]);
      check($sformatf("divchg_busy%0d", i), busy, exp_bz[i]);
      if (avg_en) strobes++;
    end
    check("divchg_strobes", strobes, SLOT_LEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
